led_pwm_peripheral: RTL
=======================

// Module: led_pwm_peripheral
// PURPOSE
// - Memory-mapped responder on the dmem bus. It decodes SB/SH/SW stores and LB/LH/LW/LBU/LHU loads.
// - Holds a 32-bit colour/duty register and a control register.
// - Drives active-high PWM for the user LED and the R/G/B LED. The top level inverts these to the pads.
// - Replaces the hard-wired LED register: the existing dmem colour sequence (0xFFFF0000 red ... 0x00FF00FF magenta) drives it unchanged.
// PARAMETERS
// - BASE_ADDR  32'hFFFFFFF8  word address of CTRL; DUTY is at BASE_ADDR+4 (0xFFFFFFFC)
// - PRESCALE   16'd47        the PWM counter advances once every PRESCALE+1 clk cycles
// PORTS
// - clk           in   1   system clock; all state updates on posedge
// - reset         in   1   asynchronous, active-low reset
// - funct3        in   3   access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
// - dmem_wren     in   1   1 = store, 0 = load
// - dmem_address  in   32  byte address
// - dmem_data_in  in   32  store data, right-aligned (byte in [7:0], half in [15:0])
// - dmem_data_out out  32  registered load data; 0 when the previous-cycle address missed
// - hit           out  1   combinational: dmem_address[31:3] matches BASE_ADDR[31:3]
// - misalign_err  out  1   one-cycle pulse, registered, on a misaligned hit
// - led           out  1   user LED PWM, active high
// - red           out  1   red PWM, active high
// - green         out  1   green PWM, active high
// - blue          out  1   blue PWM, active high
// BEHAVIOUR
// - Register map:
//   - DUTY: byte3 = led duty, byte2 = red, byte1 = green, byte0 = blue.
//   - CTRL: bit0 = EN (1 enables outputs), bit1 = IMM (1 applies DUTY immediately, not at period end). Bits [31:2] read 0.
// - Reset (reset==0, asynchronous):
//   - DUTY, active_duty, pwm_cnt, pre_cnt = 0.
//   - CTRL = 32'h1.
//   - dmem_data_out, misalign_err, led/red/green/blue = 0.
// - Stores (hit & dmem_wren, sampled on posedge):
//   - Byte lane = addr[1:0]; merged into the selected register the same edge. Other bytes keep their value.
//   - SH requires addr[0]==0; SW requires addr[1:0]==0.
//   - A misaligned store is dropped and misalign_err=1 the next cycle.
//   - A store to a reserved funct3 (011, 11x) is dropped with no error.
// - Loads (hit & !dmem_wren):
//   - The addressed lane is extracted and sign-extended (B/H) or zero-extended (BU/HU/W).
//   - The result appears on dmem_data_out after the next posedge (1-cycle latency). It is held until the next bus cycle.
//   - DUTY reads return the written value, not active_duty.
//   - A misaligned load returns 0 and pulses misalign_err.
//   - A miss (hit==0) clocks dmem_data_out to 0.
// - Prescaler:
//   - pre_cnt counts 0..PRESCALE, then wraps to 0.
//   - When pre_cnt==PRESCALE, 8-bit pwm_cnt increments and wraps 255->0.
// - Double buffering (IMM=0): active_duty <= DUTY on the edge where pwm_cnt wraps 255->0.
//   - If a store lands on that same edge, the merged new value is loaded.
//   - IMM=1: active_duty follows DUTY every cycle. The new value is visible one cycle after the store.
// - Outputs (registered): chan = EN & (active_duty[ch] > pwm_cnt).
//   - Duty 0 = always off. Duty 255 = on 255/256 of the period.
// - EN=0: all PWM outputs go to 0 on the next edge. Counters keep running, so the phase is preserved.
// - Reset mid-period or mid-access: state returns to reset values immediately. Any in-flight load data is lost (0).
// TESTING
// - Reset, then read CTRL (LW 0xFFFFFFF8) -> dmem_data_out=32'h1 one cycle later; outputs 0; misalign_err 0.
// - PRESCALE=0, SW 0xFFFFFFFC=32'hFFFF0000, IMM=0:
//   - led/red unchanged until the pwm_cnt 255->0 wrap.
//   - Afterwards led=red=1 for 255 of every 256 cycles; green=blue=0.
// - SB 0xFFFFFFFD=8'h80 over DUTY=32'h000000FF:
//   - LW reads 32'h000080FF; LB 0xFFFFFFFD reads 32'hFFFFFF80; LBU reads 32'h00000080.
//   - green duty measured at 128/256.
// - SH to 0xFFFFFFFD and LW from 0xFFFFFFFE:
//   - DUTY unchanged; misalign_err pulses once per access; load data 0.
// - Store DUTY=32'h00FF00FF on the exact wrap edge -> magenta active from that period; CTRL=0 -> all outputs 0 on the next edge.
// - Assert reset mid-period with DUTY=32'hFF00FF00 -> outputs 0 immediately; after release, DUTY reads 0 and CTRL reads 1.

Source files
------------

// File: rtl/led_pwm_peripheral.sv
// Memory-mapped LED / RGB PWM responder on the dmem bus.
// CTRL and DUTY registers with byte-lane access and a double-buffered duty register.
module led_pwm_peripheral #(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_FFF8,
    parameter logic [15:0] PRESCALE  = 16'd47
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  funct3,
    input  logic        dmem_wren,
    input  logic [31:0] dmem_address,
    input  logic [31:0] dmem_data_in,
    output logic [31:0] dmem_data_out,
    output logic        hit,
    output logic        misalign_err,
    output logic        led,
    output logic        red,
    output logic        green,
    output logic        blue
);

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_e;

    logic [31:0] r_duty;
    logic [1:0]  r_ctrl;
    logic [31:0] r_active;
    logic [15:0] r_pre_cnt;
    logic [7:0]  r_pwm_cnt;

    logic        w_sel_duty;
    logic [1:0]  w_lane;
    logic        w_size_ok;
    logic        w_aligned;
    logic [3:0]  w_be;
    logic        w_store;
    logic        w_misalign;
    logic [31:0] w_rd_word;
    logic [31:0] w_rd_shift;
    logic [31:0] w_load_data;
    logic [31:0] w_wdata;
    logic [31:0] w_duty_next;
    logic [1:0]  w_ctrl_next;
    logic        w_tick;
    logic        w_wrap;

    // BASE_ADDR is 8-byte aligned, so address bit 2 alone selects DUTY over CTRL.
    assign hit        = (dmem_address[31:3] == BASE_ADDR[31:3]);
    assign w_sel_duty = dmem_address[2];
    assign w_lane     = dmem_address[1:0];

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        w_size_ok = 1'b1;
        w_aligned = 1'b1;
        w_be      = 4'b0000;
        case (funct3)
            F3_B, F3_BU: w_be = 4'b0001 << w_lane;
            F3_H, F3_HU: begin
                w_aligned = ~w_lane[0];
                w_be      = w_lane[1] ? 4'b1100 : 4'b0011;
            end
            F3_W: begin
                w_aligned = (w_lane == 2'b00);
                w_be      = 4'b1111;
            end
            default: w_size_ok = 1'b0;
        endcase
    end

    assign w_store    = hit & dmem_wren & w_size_ok & w_aligned;
    assign w_misalign = hit & w_size_ok & ~w_aligned;

    assign w_rd_word  = w_sel_duty ? r_duty : {30'd0, r_ctrl};
    assign w_rd_shift = w_rd_word >> {w_lane, 3'b000};

    always_comb begin
        w_load_data = '0;
        if (w_size_ok && w_aligned) begin
            case (funct3)
                F3_B:    w_load_data = {{24{w_rd_shift[7]}}, w_rd_shift[7:0]};
                F3_BU:   w_load_data = {24'd0, w_rd_shift[7:0]};
                F3_H:    w_load_data = {{16{w_rd_shift[15]}}, w_rd_shift[15:0]};
                F3_HU:   w_load_data = {16'd0, w_rd_shift[15:0]};
                F3_W:    w_load_data = w_rd_word;
                default: w_load_data = '0;
            endcase
        end
    end

    // Store data arrives right-aligned; shift it into its byte lanes before merging.
    assign w_wdata = dmem_data_in << {w_lane, 3'b000};

    always_comb begin
        w_duty_next = r_duty;
        w_ctrl_next = r_ctrl;
        for (int i = 0; i < 4; i++) begin
            if (w_store && w_sel_duty && w_be[i]) w_duty_next[8*i +: 8] = w_wdata[8*i +: 8];
        end
        if (w_store && !w_sel_duty && w_be[0]) w_ctrl_next = w_wdata[1:0];
    end

    assign w_tick = (r_pre_cnt == PRESCALE);
    assign w_wrap = w_tick & (r_pwm_cnt == 8'hFF);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_duty        <= '0;
            r_ctrl        <= 2'b01;
            misalign_err  <= 1'b0;
            dmem_data_out <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
            r_duty       <= w_duty_next;
            r_ctrl       <= w_ctrl_next;
            misalign_err <= w_misalign;
            if (!hit)            dmem_data_out <= '0;
            else if (!dmem_wren) dmem_data_out <= w_load_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pre_cnt <= '0;
            r_pwm_cnt <= '0;
        end else if (w_tick) begin
            r_pre_cnt <= '0;
            r_pwm_cnt <= r_pwm_cnt + 8'd1;
        end else begin
            r_pre_cnt <= r_pre_cnt + 16'd1;
        end
    end

    // A store landing on the wrap edge is taken into the new period via the merged value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)         r_active <= '0;
        else if (r_ctrl[1]) r_active <= r_duty;
        else if (w_wrap)    r_active <= w_duty_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led   <= 1'b0;
            red   <= 1'b0;
            green <= 1'b0;
            blue  <= 1'b0;
        end else begin
            led   <= r_ctrl[0] & (r_active[31:24] > r_pwm_cnt);
            red   <= r_ctrl[0] & (r_active[23:16] > r_pwm_cnt);
            green <= r_ctrl[0] & (r_active[15:8]  > r_pwm_cnt);
            blue  <= r_ctrl[0] & (r_active[7:0]   > r_pwm_cnt);
        end
    end

endmodule
